// File: rtl/banco_reg_pkg.sv
// Shared constants and dump-engine state type for the register bank.
package banco_reg_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/banco_reg_if.sv
// Datapath read/write port plus dump channel of the register bank.
// master = lock controller / debug consumer side, slave = the register bank.
interface banco_reg_if
    import banco_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport master (
        output we3, wa3, wd3, ra1, ra2, dump_start, dump_ready,
        input  rd1, rd2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, dump_start, dump_ready,
        output rd1, rd2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

endinterface

// File: rtl/banco_reg_dump_fsm.sv
// Dump engine: walks addresses 0..DEPTH-1 over a valid/ready channel,
// then pulses done for one cycle before returning to idle.
module banco_reg_dump_fsm
    import banco_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_valid,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    dump_state_t       r_state;
    dump_state_t       w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              w_xfer;

    assign w_xfer = (r_state == DUMP_SEND) && i_ready;
    assign o_addr = r_addr;

    // State register and word address; address only returns to 0 via DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DUMP_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DUMP_DONE)
                r_addr <= '0;
            else if (w_xfer && (r_addr != LAST))
                r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Next-state: start is only looked at in IDLE, so starts while busy are dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            DUMP_IDLE: if (i_start) w_next = DUMP_SEND;
            DUMP_SEND: if (w_xfer && (r_addr == LAST)) w_next = DUMP_DONE;
            DUMP_DONE: w_next = DUMP_IDLE;
            default:   w_next = DUMP_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        o_busy  = 1'b0;
        o_valid = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            DUMP_SEND: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
            end
            DUMP_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/banco_reg_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional hard-wired zero entry, optional write-through bypass, dump engine.
module banco_reg_param
    import banco_reg_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    banco_reg_if.slave    bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_dump_data;

    // A write to the hard-wired zero entry is dropped, which also keeps it out of the bypass.
    assign w_wr_en = bus.we3 && !(ZERO_REG && (bus.wa3 == '0));

    // Storage: cleared on reset, single synchronous write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.wa3] <= bus.wd3;
        end
    end

    // Read port 1: zero rule overrides bypass, bypass overrides storage.
    always_comb begin
        w_rd1 = r_mem[bus.ra1];
        if (BYPASS && w_wr_en && (bus.ra1 == bus.wa3)) w_rd1 = bus.wd3;
        if (ZERO_REG && (bus.ra1 == '0))               w_rd1 = '0;
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        w_rd2 = r_mem[bus.ra2];
        if (BYPASS && w_wr_en && (bus.ra2 == bus.wa3)) w_rd2 = bus.wd3;
        if (ZERO_REG && (bus.ra2 == '0))               w_rd2 = '0;
    end

    // Dump word: live stored value, never bypassed.
    always_comb begin
        w_dump_data = r_mem[bus.dump_addr];
        if (ZERO_REG && (bus.dump_addr == '0)) w_dump_data = '0;
    end

    assign bus.rd1       = w_rd1;
    assign bus.rd2       = w_rd2;
    assign bus.dump_data = w_dump_data;

    banco_reg_dump_fsm #(
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (bus.dump_start),
        .i_ready (bus.dump_ready),
        .o_busy  (bus.dump_busy),
        .o_valid (bus.dump_valid),
        .o_done  (bus.dump_done),
        .o_addr  (bus.dump_addr)
    );

endmodule

// File: tb/tb_banco_reg_param.sv
// Bench for banco_reg_param: two instances (ZERO_REG/BYPASS on, and both off)
// driven identically and compared every cycle against a behavioural model.
module tb_banco_reg_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;
    localparam bit CFG_ZERO [2] = '{1'b1, 1'b0};
    localparam bit CFG_BYP  [2] = '{1'b1, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          we3        = 1'b0;
    logic [AW-1:0] wa3        = '0;
    logic [DW-1:0] wd3        = '0;
    logic [AW-1:0] ra1        = '0;
    logic [AW-1:0] ra2        = '0;
    logic          dump_start = 1'b0;
    logic          dump_ready = 1'b0;

    banco_reg_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    banco_reg_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    assign bus_a.we3 = we3;  assign bus_b.we3 = we3;
    assign bus_a.wa3 = wa3;  assign bus_b.wa3 = wa3;
    assign bus_a.wd3 = wd3;  assign bus_b.wd3 = wd3;
    assign bus_a.ra1 = ra1;  assign bus_b.ra1 = ra1;
    assign bus_a.ra2 = ra2;  assign bus_b.ra2 = ra2;
    assign bus_a.dump_start = dump_start;  assign bus_b.dump_start = dump_start;
    assign bus_a.dump_ready = dump_ready;  assign bus_b.dump_ready = dump_ready;

    banco_reg_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    banco_reg_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_phase;   // -1 idle, 0..DEPTH-1 word being offered, DEPTH done pulse

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int done_cyc = -1;
    int first_word_cyc = -1;

    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_da   [$];
    logic [DW-1:0] q_db   [$];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < DEPTH; a++)
                m_mem[c][a] = '0;
        m_phase = -1;
    endfunction

    function automatic logic [DW-1:0] m_stored(int c, logic [AW-1:0] a);
        if (CFG_ZERO[c] && a == 0) return '0;
        return m_mem[c][a];
    endfunction

    function automatic logic [DW-1:0] m_read(int c, logic [AW-1:0] ra);
        if (CFG_ZERO[c] && ra == 0) return '0;
        if (CFG_BYP[c] && we3 && ra == wa3 && !(CFG_ZERO[c] && wa3 == 0)) return wd3;
        return m_mem[c][ra];
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_phase < 0) begin
            if (dump_start) m_phase = 0;
        end else if (m_phase < DEPTH) begin
            if (dump_ready) m_phase = m_phase + 1;
        end else begin
            m_phase = -1;
        end
        if (we3)
            for (int c = 0; c < 2; c++)
                if (!(CFG_ZERO[c] && wa3 == 0)) m_mem[c][wa3] = wd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle comparison of both instances against the model, plus dump capture.
    task automatic compare_all();
        logic          e_valid, e_busy, e_done;
        logic [AW-1:0] e_addr;
        e_valid = (m_phase >= 0) && (m_phase < DEPTH);
        e_busy  = (m_phase >= 0);
        e_done  = (m_phase == DEPTH);
        e_addr  = (m_phase < 0) ? AW'(0) : (m_phase == DEPTH) ? AW'(DEPTH - 1) : AW'(m_phase);
        chk("A.rd1",   bus_a.rd1, m_read(0, ra1));
        chk("A.rd2",   bus_a.rd2, m_read(0, ra2));
        chk("B.rd1",   bus_b.rd1, m_read(1, ra1));
        chk("B.rd2",   bus_b.rd2, m_read(1, ra2));
        chk("A.valid", bus_a.dump_valid, e_valid);
        chk("A.busy",  bus_a.dump_busy,  e_busy);
        chk("A.done",  bus_a.dump_done,  e_done);
        chk("A.addr",  bus_a.dump_addr,  e_addr);
        chk("A.ddata", bus_a.dump_data,  m_stored(0, e_addr));
        chk("B.valid", bus_b.dump_valid, e_valid);
        chk("B.done",  bus_b.dump_done,  e_done);
        chk("B.addr",  bus_b.dump_addr,  e_addr);
        chk("B.ddata", bus_b.dump_data,  m_stored(1, e_addr));
        if (bus_a.dump_valid && dump_ready) begin
            if (q_addr.size() == 0) first_word_cyc = cyc;
            q_addr.push_back(bus_a.dump_addr);
            q_da.push_back(bus_a.dump_data);
            q_db.push_back(bus_b.dump_data);
        end
        if (bus_a.dump_done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic clear_q();
        q_addr.delete(); q_da.delete(); q_db.delete();
        first_word_cyc = -1;
    endtask

    task automatic do_reset();
        we3 = 1'b0; dump_start = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.A.busy",  bus_a.dump_busy,  0);
        chk("rst.A.valid", bus_a.dump_valid, 0);
        chk("rst.A.done",  bus_a.dump_done,  0);
        chk("rst.A.addr",  bus_a.dump_addr,  0);
        chk("rst.B.valid", bus_b.dump_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        if (n_done == d0) chk({name, ".timeout"}, 1, 0);
    endtask

    task automatic check_dump(input string name, input bit after_reset);
        chk({name, ".count"}, q_addr.size(), DEPTH);
        for (int i = 0; i < q_addr.size() && i < DEPTH; i++) begin
            chk({name, ".addr"}, q_addr[i], i);
            if (after_reset) begin
                chk({name, ".dataA"}, q_da[i], 0);
                chk({name, ".dataB"}, q_db[i], 0);
            end else begin
                chk({name, ".dataA"}, q_da[i], (i == 0) ? 0 : 32'h10 + i);
                chk({name, ".dataB"}, q_db[i], 32'h10 + i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int start_cyc;
        int d0;
        int k;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Reset contents on every address.
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = AW'(i); ra2 = AW'(DEPTH - 1 - i);
            #1;
            chk("rst.A.rd1", bus_a.rd1, 0);
            chk("rst.B.rd2", bus_b.rd2, 0);
            tick();
        end

        // Write-through bypass vs stored value.
        we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hA5; ra1 = 3'd3; ra2 = 3'd0;
        #1;
        chk("byp.A.same", bus_a.rd1, 8'hA5);
        chk("byp.B.same", bus_b.rd1, 8'h00);
        tick();
        we3 = 1'b0;
        #1;
        chk("byp.A.next", bus_a.rd1, 8'hA5);
        chk("byp.B.next", bus_b.rd1, 8'hA5);
        tick();

        // Hard-wired zero entry.
        we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hFF; ra1 = 3'd0;
        #1;
        chk("zero.A.same", bus_a.rd1, 8'h00);
        chk("zero.B.same", bus_b.rd1, 8'h00);
        tick();
        we3 = 1'b0;
        #1;
        chk("zero.A.next", bus_a.rd1, 8'h00);
        chk("zero.B.next", bus_b.rd1, 8'hFF);
        tick();

        // Load pattern, then a dump with ready held high.
        for (int i = 0; i < DEPTH; i++) begin
            we3 = 1'b1; wa3 = AW'(i); wd3 = DW'(8'h10 + i);
            tick();
        end
        we3 = 1'b0;
        clear_q();
        dump_ready = 1'b1; dump_start = 1'b1;
        start_cyc = cyc;
        d0 = n_done;
        tick();
        dump_start = 1'b0;
        wait_done("dump1", 40);
        check_dump("dump1", 1'b0);
        chk("dump1.first_cyc", first_word_cyc, start_cyc + 1);
        chk("dump1.done_cyc",  done_cyc, start_cyc + DEPTH + 1);
        chk("dump1.done_cnt",  n_done, d0 + 1);
        tick();
        chk("dump1.idle_busy", bus_a.dump_busy, 0);

        // Dump with toggling ready and a re-pulsed start mid-dump.
        clear_q();
        d0 = n_done;
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        k = 0;
        while (n_done == d0 && k < 60) begin
            dump_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
            dump_start = (k == 5) ? 1'b1 : 1'b0;
            ra1 = AW'($urandom_range(0, DEPTH - 1));
            ra2 = AW'($urandom_range(0, DEPTH - 1));
            tick();
            k++;
        end
        dump_start = 1'b0;
        if (n_done == d0) chk("dump2.timeout", 1, 0);
        repeat (3) tick();
        check_dump("dump2", 1'b0);
        chk("dump2.done_cnt", n_done, d0 + 1);

        // Randomised traffic on both the datapath and the dump channel.
        for (int i = 0; i < 300; i++) begin
            we3        = 1'($urandom_range(0, 1));
            wa3        = AW'($urandom_range(0, DEPTH - 1));
            wd3        = DW'($urandom);
            ra1        = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom_range(0, DEPTH - 1));
            ra2        = AW'($urandom_range(0, DEPTH - 1));
            dump_start = ($urandom_range(0, 7) == 0);
            dump_ready = 1'($urandom_range(0, 1));
            tick();
        end
        we3 = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        k = 0;
        while (bus_a.dump_busy && k < 40) begin
            tick();
            k++;
        end
        chk("rand.drain", bus_a.dump_busy, 0);

        // Reset during a dump after four words.
        clear_q();
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        k = 0;
        while (q_addr.size() < 4 && k < 20) begin
            tick();
            k++;
        end
        chk("abort.words", q_addr.size(), 4);
        d0 = n_done;
        do_reset();
        repeat (3) tick();
        chk("abort.no_done", n_done, d0);
        chk("abort.no_more", q_addr.size(), 4);

        // Fresh dump after the abort starts from address 0 with cleared contents.
        clear_q();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_done("dump3", 40);
        check_dump("dump3", 1'b1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/banco_reg_param.md
# banco_reg_param

Parametrised successor to the 8×8 lock register bank: a 2^ADDR_W × DATA_W register file with two asynchronous read ports, one synchronous write port, an optional hard-wired zero entry and optional write-through bypass. A built-in dump engine streams every entry out over a valid/ready channel so the lock's display/debug path can read the whole bank without stealing the datapath read ports. It sits between the lock controller datapath (ALU/compare logic on rd1/rd2) and the display/UART debug logic on the dump channel.

## Interface
- DATA_W, 8, entry width in bits (≥1)
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W entries (ADDR_W ≥ 1)
- ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes; 0: entry 0 is ordinary storage
- BYPASS, 1, 1: a read of the address being written this cycle returns wd3; 0: it returns the stored value
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we3  in  1  write enable
- wa3  in  ADDR_W  write address
- wd3  in  DATA_W  write data
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data, combinational
- dump_start  in  1  request a full-bank dump (level sampled each cycle)
- dump_busy  out  1  dump engine not idle
- dump_valid  out  1  dump word present
- dump_ready  in  1  consumer accepts word
- dump_addr  out  ADDR_W  address of current dump word
- dump_data  out  DATA_W  contents of entry dump_addr
- dump_done  out  1  one-cycle pulse after last word accepted

## Operation
- Reset (rst_n low, asynchronous): every entry cleared to 0; dump FSM to IDLE; dump_busy, dump_valid, dump_done = 0; dump_addr = 0. rd1/rd2 therefore read 0.
- Write: on rising clk with we3 = 1 and rst_n = 1, entry wa3 ← wd3. With ZERO_REG = 1, writes to address 0 are dropped.
- Read: rdN = 0 if ZERO_REG and raN = 0; else wd3 if BYPASS and we3 and raN = wa3 (and not the dropped zero case); else stored entry raN. Both ports may address the same entry.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start = 1 → SEND, dump_addr = 0.
  - SEND: dump_valid = 1, dump_busy = 1. On dump_valid & dump_ready: if dump_addr = DEPTH−1 → DONE, else dump_addr + 1. No transfer → hold.
  - DONE: dump_done = 1, dump_busy = 1, dump_valid = 0; next cycle → IDLE, dump_addr = 0.
- dump_start while busy is ignored (not queued); a start held high across DONE begins a new dump on the IDLE cycle after.
- dump_data is the live stored value of entry dump_addr (no bypass; zero rule applies). A write to dump_addr while stalled changes dump_data — accepted behaviour; consumer samples at the handshake.
- Datapath reads/writes are unaffected by dump activity.

## Timing
- Write → visible on rd1/rd2 the cycle after the clk edge; same cycle when BYPASS = 1.
- dump_start seen at edge N → dump_valid high in cycle N+1 with addr 0.
- dump_ready held high: one word per cycle, DEPTH words in cycles N+1..N+DEPTH, dump_done in N+DEPTH+1, dump_busy low from N+DEPTH+2.
- dump_addr wraps only via DONE → IDLE reset to 0; never increments past DEPTH−1.
- rst_n asserted mid-dump: immediate abort, no dump_done pulse.

## Structure
- Shared package banco_reg_pkg: default DATA_W/ADDR_W constants, dump state enum (IDLE, SEND, DONE).
- Sub-module banco_reg_dump_fsm: state, dump_addr counter, handshake outputs; the top holds storage, read muxing and bypass.

## Test plan
- Reset then read all 8 addresses → all 0; dump_busy/valid/done = 0.
- Write 0xA5 to addr 3, read ra1 = 3 same cycle → 0xA5 (BYPASS = 1); next cycle 0xA5; with BYPASS = 0 same-cycle read returns 0x00.
- Write 0xFF to addr 0 with ZERO_REG = 1 → rd1 at ra1 = 0 stays 0x00; with ZERO_REG = 0 → 0xFF.
- Load entries i ← 0x10+i, pulse dump_start, ready always 1 → words (0,0x00),(1,0x11)…(7,0x17) on 8 consecutive cycles, dump_done one cycle later.
- Dump with ready toggling 1-0-1-0, dump_start re-pulsed mid-dump → 8 words in order, no duplicates, second start ignored.
- Assert rst_n low after 4 dump words → all outputs 0 immediately, no dump_done; next dump restarts at addr 0.
